// File: rtl/seg7_autorange_pkg.sv
// seg7_pkg: shared types, glyph constants and the BCD-to-segment helper for
// the auto-ranging 7-segment display controller.
//   bcd_t      : one BCD digit
//   seg_t      : one glyph, index 0 = segment a ... index 6 = segment g,
//                active low (literal MSB is segment a)
//   bcd_to_seg : 0-9 -> standard glyph, 10-15 -> dash
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [0:6] seg_t;

  localparam seg_t SEG_ZERO  = 7'b0000001;
  localparam seg_t SEG_ONE   = 7'b1001111;
  localparam seg_t SEG_TWO   = 7'b0010010;
  localparam seg_t SEG_THREE = 7'b0000110;
  localparam seg_t SEG_FOUR  = 7'b1001100;
  localparam seg_t SEG_FIVE  = 7'b0100100;
  localparam seg_t SEG_SIX   = 7'b0100000;
  localparam seg_t SEG_SEVEN = 7'b0001111;
  localparam seg_t SEG_EIGHT = 7'b0000000;
  localparam seg_t SEG_NINE  = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b1111110;

  // Non-decimal codes render as a dash so a corrupt digit is visible.
  function automatic seg_t bcd_to_seg(input bcd_t bcd);
    seg_t s;
    case (bcd)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = SEG_ONE;
      4'd2:    s = SEG_TWO;
      4'd3:    s = SEG_THREE;
      4'd4:    s = SEG_FOUR;
      4'd5:    s = SEG_FIVE;
      4'd6:    s = SEG_SIX;
      4'd7:    s = SEG_SEVEN;
      4'd8:    s = SEG_EIGHT;
      4'd9:    s = SEG_NINE;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_autorange_if.sv
// seg7_autorange_if: groups the measurement input and display output signals.
//   master : producer side (BCD converter / testbench) drives the inputs
//   slave  : the display controller
//   tick_1ms, value_bcd, value_valid, blank_lz_en, blink_en : to controller
//   seg, range_onehot                                       : from controller
interface seg7_autorange_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_BCD    = 6
);

  logic                              tick_1ms;
  logic [4*NUM_BCD-1:0]              value_bcd;
  logic                              value_valid;
  logic                              blank_lz_en;
  logic                              blink_en;
  logic [7*NUM_DIGITS-1:0]           seg;
  logic [NUM_BCD-NUM_DIGITS:0]       range_onehot;

  modport master (
    output tick_1ms, value_bcd, value_valid, blank_lz_en, blink_en,
    input  seg, range_onehot
  );

  modport slave (
    input  tick_1ms, value_bcd, value_valid, blank_lz_en, blink_en,
    output seg, range_onehot
  );

endinterface

// File: rtl/seg7_autorange_digit_dec.sv
// seg7_digit_dec: combinational decoder for one display digit.
//   bcd   : digit value
//   blank : force the digit dark
//   seg   : active-low glyph
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  input  logic blank,
  output seg_t seg
);

  // Glyph select with blank override
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = bcd_to_seg(bcd);
    end
  end

endmodule

// File: rtl/seg7_autorange.sv
// seg7_autorange: auto-ranging BCD to multi-digit 7-segment display driver.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of seg7_autorange_if (value capture, tick, display
//              options in; registered seg and range_onehot out)
// The display window follows the most significant nonzero digit; a move to a
// smaller range only happens after it has been requested for HYST_MS ticks.
module seg7_autorange
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_BCD         = 6,
  parameter int HYST_MS         = 100,
  parameter int BLINK_PERIOD_MS = 1000,
  parameter int BLINK_ON_MS     = 800
) (
  input logic             clk,
  input logic             rst,
  seg7_autorange_if.slave bus
);

  localparam int NUM_RANGES = NUM_BCD - NUM_DIGITS + 1;
  localparam int SHIFT_W    = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1;
  localparam int HYST_W     = (HYST_MS > 1) ? $clog2(HYST_MS) : 1;
  localparam int BLINK_W    = (BLINK_PERIOD_MS > 1) ? $clog2(BLINK_PERIOD_MS) : 1;

  localparam logic [HYST_W-1:0]  HYST_LAST  = HYST_W'(HYST_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_ON   = BLINK_W'(BLINK_ON_MS);

  logic [4*NUM_BCD-1:0]    val_q, val_d;
  logic                    loaded_q, loaded_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic [HYST_W-1:0]       hyst_cnt_q, hyst_cnt_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_RANGES-1:0]   range_q, range_d;

  logic [SHIFT_W-1:0]      s_req_s;
  logic                    blink_off_s;
  bcd_t                    win_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_s;
  seg_t                    dig_seg_s [NUM_DIGITS];

  // Capture the measurement; loaded_q keeps the display dark until the first value
  always_comb begin
    loaded_d = loaded_q | bus.value_valid;
    if (bus.value_valid) begin
      val_d = bus.value_bcd;
    end else begin
      val_d = val_q;
    end
  end

  // Requested shift from the most significant nonzero digit (codes >9 count as nonzero)
  always_comb begin
    int msd;
    msd = 0;
    for (int k = 0; k < NUM_BCD; k++) begin
      if (val_q[4*k +: 4] != 4'd0) begin
        msd = k;
      end else begin
        msd = msd;
      end
    end
    if (msd >= NUM_DIGITS - 1) begin
      s_req_s = SHIFT_W'(msd - (NUM_DIGITS - 1));
    end else begin
      s_req_s = '0;
    end
  end

  // Range update: upshift at once, downshift only after HYST_MS consecutive ticks
  always_comb begin
    shift_d    = shift_q;
    hyst_cnt_d = hyst_cnt_q;
    if (s_req_s > shift_q) begin
      shift_d    = s_req_s;
      hyst_cnt_d = '0;
    end else if (s_req_s == shift_q) begin
      hyst_cnt_d = '0;
    end else if (bus.tick_1ms) begin
      // Any smaller request keeps counting, even if its value moves around
      if (hyst_cnt_q == HYST_LAST) begin
        shift_d    = s_req_s;
        hyst_cnt_d = '0;
      end else begin
        hyst_cnt_d = hyst_cnt_q + HYST_W'(1);
      end
    end else begin
      hyst_cnt_d = hyst_cnt_q;
    end
  end

  // Blink phase counter, parked at zero while blink is disabled
  always_comb begin
    if (!bus.blink_en) begin
      blink_cnt_d = '0;
    end else if (bus.tick_1ms) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
    // Uses the next count so the registered glyphs match the registered counter
    blink_off_s = bus.blink_en && (blink_cnt_d >= BLINK_ON);
  end

  // Display window at the new shift, plus leading-zero blanking inside that window
  always_comb begin
    logic zero_above;
    lz_s       = '0;
    zero_above = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      win_s[d] = val_q[4*(d + int'(shift_d)) +: 4];
    end
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_above = zero_above && (win_s[d] == 4'd0);
      lz_s[d]    = bus.blank_lz_en && zero_above;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    seg7_digit_dec u_dec (
      .bcd   (win_s[d]),
      .blank (lz_s[d] | blink_off_s | ~loaded_q),
      .seg   (dig_seg_s[d])
    );
  end

  // Pack glyphs onto the pin vector (glyph index 0 = segment a = pin bit 0)
  always_comb begin
    seg_d   = '0;
    range_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      for (int k = 0; k < 7; k++) begin
        seg_d[7*d + k] = dig_seg_s[d][k];
      end
    end
    for (int k = 0; k < NUM_RANGES; k++) begin
      range_d[k] = (shift_d == SHIFT_W'(k));
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q       <= '0;
      loaded_q    <= 1'b0;
      shift_q     <= '0;
      hyst_cnt_q  <= '0;
      blink_cnt_q <= '0;
      seg_q       <= '1;
      range_q     <= NUM_RANGES'(1);
    end else begin
      val_q       <= val_d;
      loaded_q    <= loaded_d;
      shift_q     <= shift_d;
      hyst_cnt_q  <= hyst_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      seg_q       <= seg_d;
      range_q     <= range_d;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.range_onehot = range_q;

endmodule

// File: tb/tb_seg7_autorange.sv
module tb_seg7_autorange;

  localparam int ND    = 4;
  localparam int NB    = 6;
  localparam int NR    = NB - ND + 1;
  localparam int HYST  = 100;
  localparam int BPER  = 1000;
  localparam int BON   = 800;
  localparam int BL    = 16;  // code for a dark digit
  localparam int DA    = 10;  // any non-decimal code shows a dash

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_autorange_if #(.NUM_DIGITS(ND), .NUM_BCD(NB)) bus ();

  seg7_autorange #(
    .NUM_DIGITS(ND), .NUM_BCD(NB), .HYST_MS(HYST),
    .BLINK_PERIOD_MS(BPER), .BLINK_ON_MS(BON)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cur_lz   = 1'b0;
  bit cur_ben  = 1'b0;

  // Reference model state
  int              m_dig [NB];
  bit              m_loaded;
  int              m_shift, m_hyst, m_blink;
  logic [7*ND-1:0] m_seg;
  logic [NR-1:0]   m_range;

  // Pin pattern of a glyph: lit-segment mask (bit0 = a) inverted for active low
  function automatic logic [6:0] glyph(input int code);
    logic [6:0] lit;
    case (code)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  9: lit = 7'h6F;  BL: lit = 7'h00;
      default: lit = 7'h40;
    endcase
    return ~lit;
  endfunction

  function automatic logic [7*ND-1:0] exp_seg(input int c3, c2, c1, c0);
    return {glyph(c3), glyph(c2), glyph(c1), glyph(c0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) m_dig[k] = 0;
    m_loaded = 1'b0;
    m_shift  = 0;
    m_hyst   = 0;
    m_blink  = 0;
    m_seg    = '1;
    m_range  = NR'(1);
  endtask

  // One clock of the specified behaviour; outputs reflect the state before capture
  task automatic model_step(input bit valid, input logic [4*NB-1:0] value, input bit tick);
    int h, sreq, top, code;
    h = 0;
    for (int k = 0; k < NB; k++) if (m_dig[k] != 0) h = k;
    sreq = (h > ND - 1) ? h - (ND - 1) : 0;
    if (sreq > m_shift) begin
      m_shift = sreq; m_hyst = 0;
    end else if (sreq == m_shift) begin
      m_hyst = 0;
    end else if (tick) begin
      if (m_hyst == HYST - 1) begin m_shift = sreq; m_hyst = 0; end
      else m_hyst++;
    end
    if (!cur_ben) m_blink = 0;
    else if (tick) m_blink = (m_blink + 1) % BPER;
    top = -1;
    for (int d = 0; d < ND; d++) if (m_dig[d + m_shift] != 0) top = d;
    for (int d = 0; d < ND; d++) begin
      code = m_dig[d + m_shift];
      if (!m_loaded || (cur_ben && m_blink >= BON)) code = BL;
      else if (cur_lz && d > 0 && d > top) code = BL;
      m_seg[7*d +: 7] = glyph(code);
    end
    m_range = NR'(1) << m_shift;
    if (valid) begin
      for (int k = 0; k < NB; k++) m_dig[k] = int'(value[4*k +: 4]);
      m_loaded = 1'b1;
    end
  endtask

  // Drive one cycle, then compare pins against the model
  task automatic step(input bit valid, input logic [4*NB-1:0] value, input bit tick);
    bus.value_valid = valid;
    bus.value_bcd   = value;
    bus.tick_1ms    = tick;
    bus.blank_lz_en = cur_lz;
    bus.blink_en    = cur_ben;
    @(posedge clk); #1;
    model_step(valid, value, tick);
    chk("model_seg", 32'(bus.seg), 32'(m_seg));
    chk("model_range", 32'(bus.range_onehot), 32'(m_range));
    bus.value_valid = 1'b0;
    bus.tick_1ms    = 1'b0;
  endtask

  task automatic load(input logic [4*NB-1:0] value);
    step(1'b1, value, 1'b0);
    step(1'b0, value, 1'b0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
    end
  endtask

  // Reset asserted #1 after an edge: outputs must clear before the next edge
  task automatic async_reset(input string name);
    rst = 1'b1;
    #2;
    chk({name, "_seg"}, 32'(bus.seg), 32'(28'hFFFFFFF));
    chk({name, "_range"}, 32'(bus.range_onehot), 32'(3'b001));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [23:0] value;
    bit          lz;
    int          c3, c2, c1, c0;
    logic [2:0]  range;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{24'h000123, 1'b0, 0, 1, 2, 3, 3'b001};
    vecs[1]  = '{24'h000123, 1'b1, BL, 1, 2, 3, 3'b001};
    vecs[2]  = '{24'h00000C, 1'b0, 0, 0, 0, DA, 3'b001};
    vecs[3]  = '{24'h00000C, 1'b1, BL, BL, BL, DA, 3'b001};
    vecs[4]  = '{24'h000000, 1'b1, BL, BL, BL, 0, 3'b001};
    vecs[5]  = '{24'h012345, 1'b0, 1, 2, 3, 4, 3'b010};
    vecs[6]  = '{24'h123456, 1'b0, 1, 2, 3, 4, 3'b100};
    vecs[7]  = '{24'h000042, 1'b0, 0, 0, 0, 0, 3'b100};
    vecs[8]  = '{24'h000042, 1'b1, BL, BL, BL, 0, 3'b100};
    vecs[9]  = '{24'h0A0000, 1'b1, BL, DA, 0, 0, 3'b100};
    vecs[10] = '{24'h100000, 1'b0, 1, 0, 0, 0, 3'b100};

    rst             = 1'b1;
    bus.tick_1ms    = 1'b0;
    bus.value_bcd   = '0;
    bus.value_valid = 1'b0;
    bus.blank_lz_en = 1'b0;
    bus.blink_en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seg", 32'(bus.seg), 32'(28'hFFFFFFF));
    chk("reset_range", 32'(bus.range_onehot), 32'(3'b001));
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0);
    chk("blank_before_valid", 32'(bus.seg), 32'(28'hFFFFFFF));

    // Table: value captured at N, checked at N+2
    for (int i = 0; i < 11; i++) begin
      cur_lz = vecs[i].lz;
      load(vecs[i].value);
      chk($sformatf("vec%0d_seg", i), 32'(bus.seg),
          32'(exp_seg(vecs[i].c3, vecs[i].c2, vecs[i].c1, vecs[i].c0)));
      chk($sformatf("vec%0d_range", i), 32'(bus.range_onehot), 32'(vecs[i].range));
    end
    cur_lz = 1'b0;

    // Downshift after exactly HYST_MS ticks
    load(24'h123456);
    load(24'h000042);
    run_ticks(HYST - 1);
    chk("hyst99_range", 32'(bus.range_onehot), 32'(3'b100));
    chk("hyst99_seg", 32'(bus.seg), 32'(exp_seg(0, 0, 0, 0)));
    run_ticks(1);
    chk("hyst100_range", 32'(bus.range_onehot), 32'(3'b001));
    chk("hyst100_seg", 32'(bus.seg), 32'(exp_seg(0, 0, 4, 2)));

    // Smaller request changing mid-count keeps the count
    load(24'h123456);
    load(24'h000042);
    run_ticks(50);
    load(24'h099999);
    run_ticks(HYST - 51);
    chk("fluct99_range", 32'(bus.range_onehot), 32'(3'b100));
    run_ticks(1);
    chk("fluct100_range", 32'(bus.range_onehot), 32'(3'b010));
    chk("fluct100_seg", 32'(bus.seg), 32'(exp_seg(9, 9, 9, 9)));

    // A request equal to the current range restarts the count
    load(24'h123456);
    load(24'h000042);
    run_ticks(50);
    step(1'b1, 24'h123456, 1'b0);
    load(24'h000042);
    run_ticks(50);
    chk("restart_range", 32'(bus.range_onehot), 32'(3'b100));
    run_ticks(50);
    chk("restart_done_range", 32'(bus.range_onehot), 32'(3'b001));

    // Blink window
    async_reset("rst_blink");
    cur_ben = 1'b1;
    load(24'h000042);
    run_ticks(BON - 1);
    chk("blink799", 32'(bus.seg), 32'(exp_seg(0, 0, 4, 2)));
    run_ticks(1);
    chk("blink800", 32'(bus.seg), 32'(28'hFFFFFFF));
    chk("blink800_range", 32'(bus.range_onehot), 32'(3'b001));
    run_ticks(BPER - BON - 1);
    chk("blink999", 32'(bus.seg), 32'(28'hFFFFFFF));
    run_ticks(1);
    chk("blink1000", 32'(bus.seg), 32'(exp_seg(0, 0, 4, 2)));
    run_ticks(900);
    chk("blink1900", 32'(bus.seg), 32'(28'hFFFFFFF));
    cur_ben = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("blink_release", 32'(bus.seg), 32'(exp_seg(0, 0, 4, 2)));

    // Dash glyph, then reset in the middle of a pending downshift
    load(24'h00000C);
    chk("dash_seg", 32'(bus.seg), 32'(exp_seg(0, 0, 0, DA)));
    load(24'h123456);
    load(24'h000042);
    run_ticks(60);
    async_reset("rst_hyst");
    step(1'b0, '0, 1'b1);
    chk("post_rst_seg", 32'(bus.seg), 32'(28'hFFFFFFF));
    load(24'h000042);
    chk("post_rst_load", 32'(bus.seg), 32'(exp_seg(0, 0, 4, 2)));

    // Randomised traffic against the model
    for (int i = 0; i < 6000; i++) begin
      logic [23:0] v;
      int nd;
      v  = '0;
      nd = $urandom_range(0, NB);
      for (int k = 0; k < nd; k++) begin
        if ($urandom_range(0, 15) < 14) v[4*k +: 4] = 4'($urandom_range(0, 9));
        else v[4*k +: 4] = 4'($urandom_range(10, 15));
      end
      if ($urandom_range(0, 199) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 299) == 0) cur_ben = ~cur_ben;
      step(($urandom_range(0, 39) == 0), v, ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
